param_project_mux: RTL and testbench

PARAM_PROJECT_MUX -- requirements
Module: param_project_mux

---
 rtl/param_project_mux_pkg.sv | 18 +
 rtl/param_project_mux_if.sv | 32 +++
 rtl/param_project_mux_guard_fsm.sv | 90 +++++++++
 rtl/param_project_mux.sv | 71 +++++++
 tb/tb_param_project_mux.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/param_project_mux_pkg.sv
// Shared types and default sizing for the project multiplexer.
package param_project_mux_pkg;

   typedef enum logic [1:0] {
      ST_OFF     = 2'd0,
      ST_ISOLATE = 2'd1,
      ST_ENABLE  = 2'd2,
      ST_ACTIVE  = 2'd3
   } mux_state_e;

   localparam int DEF_N_PROJ = 16;
   localparam int DEF_ADDR_W = 5;
   localparam int DEF_IW_W   = 18;
   localparam int DEF_OW_W   = 24;
   localparam int DEF_GUARD  = 2;
   localparam int CNT_W      = 4;

endpackage

// File: rtl/param_project_mux_if.sv
// Bundle between the shared harness side (master) and the multiplexer (slave).
interface param_project_mux_if
   import param_project_mux_pkg::*;
#(
   parameter int N_PROJ = DEF_N_PROJ,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int IW_W   = DEF_IW_W,
   parameter int OW_W   = DEF_OW_W
) ();

   logic                     ena;
   logic [ADDR_W-1:0]        addr;
   logic                     sel_load;
   logic [IW_W-1:0]          iw;
   logic [N_PROJ-1:0]        proj_ena;
   logic [N_PROJ*IW_W-1:0]   proj_iw;
   logic [N_PROJ*OW_W-1:0]   proj_ow;
   logic [OW_W-1:0]          ow;
   logic                     busy;
   logic [ADDR_W-1:0]        cur_addr;

   modport master (
      output ena, addr, sel_load, iw, proj_ow,
      input  proj_ena, proj_iw, ow, busy, cur_addr
   );

   modport slave (
      input  ena, addr, sel_load, iw, proj_ow,
      output proj_ena, proj_iw, ow, busy, cur_addr
   );

endinterface

// File: rtl/param_project_mux_guard_fsm.sv
// Break-before-make sequencer: owns the state, guard down-counter and latched address.
//
// state      | meaning
// ST_OFF     | no project enabled, waiting for a valid sel_load
// ST_ISOLATE | all enables low, guard counter running down
// ST_ENABLE  | selected project enabled, output not yet captured
// ST_ACTIVE  | selected project enabled, output captured every cycle
module mux_guard_fsm
   import param_project_mux_pkg::*;
#(
   parameter int N_PROJ = DEF_N_PROJ,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int GUARD  = DEF_GUARD
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ena_i,
   input  logic              sel_load_i,
   input  logic [ADDR_W-1:0] addr_i,
   output logic [ADDR_W-1:0] cur_addr_o,
   output logic              en_o,
   output logic              busy_o,
   output logic              hold_o
);

   localparam logic [ADDR_W:0] ADDR_LIM = (ADDR_W+1)'(N_PROJ);

   mux_state_e        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              en_q, busy_q;
   logic              addr_ok;

   assign addr_ok = ({1'b0, addr_i} < ADDR_LIM);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      if (!ena_i) begin
         state_d = ST_OFF;
         cnt_d   = '0;
      end else if (sel_load_i && !addr_ok) begin
         addr_d  = addr_i;
         state_d = ST_OFF;
         cnt_d   = '0;
      end else if (sel_load_i && !((state_q == ST_ACTIVE) && (addr_i == addr_q))) begin
         // re-selecting the live project must not disturb it
         addr_d  = addr_i;
         state_d = ST_ISOLATE;
         cnt_d   = CNT_W'(GUARD);
      end else begin
         case (state_q)
            ST_ISOLATE: begin
               if (cnt_q <= CNT_W'(1)) begin
                  state_d = ST_ENABLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
            ST_ENABLE: state_d = ST_ACTIVE;
            default:   ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_OFF;
         cnt_q   <= '0;
         addr_q  <= '0;
         en_q    <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         en_q    <= (state_d == ST_ENABLE) || (state_d == ST_ACTIVE);
         busy_q  <= (state_d == ST_ISOLATE) || (state_d == ST_ENABLE);
      end
   end

   assign cur_addr_o = addr_q;
   assign en_o       = en_q;
   assign busy_o     = busy_q;
   // true only across an ACTIVE->ACTIVE edge, so ow stays 0 on the first ACTIVE cycle
   assign hold_o     = (state_q == ST_ACTIVE) && (state_d == ST_ACTIVE);

endmodule

// File: rtl/param_project_mux.sv
// Project multiplexer top: one-hot enable decode, input gating and registered output select.
module param_project_mux
   import param_project_mux_pkg::*;
#(
   parameter int N_PROJ = DEF_N_PROJ,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int IW_W   = DEF_IW_W,
   parameter int OW_W   = DEF_OW_W,
   parameter int GUARD  = DEF_GUARD
) (
   input  logic               clk,
   input  logic               rst,
   param_project_mux_if.slave bus
);

   logic [ADDR_W-1:0]      cur_addr;
   logic                   en;
   logic                   busy;
   logic                   hold;
   logic [N_PROJ-1:0]      proj_ena;
   logic [N_PROJ*IW_W-1:0] proj_iw;
   logic [OW_W-1:0]        ow_slot;
   logic [OW_W-1:0]        ow_q;

   mux_guard_fsm #(
      .N_PROJ (N_PROJ),
      .ADDR_W (ADDR_W),
      .GUARD  (GUARD)
   ) u_fsm (
      .clk        (clk),
      .rst        (rst),
      .ena_i      (bus.ena),
      .sel_load_i (bus.sel_load),
      .addr_i     (bus.addr),
      .cur_addr_o (cur_addr),
      .en_o       (en),
      .busy_o     (busy),
      .hold_o     (hold)
   );

   // decode is driven only by flops, so at most one enable can be high
   always_comb begin
      proj_ena = '0;
      ow_slot  = '0;
      for (int k = 0; k < N_PROJ; k++) begin
         if (cur_addr == ADDR_W'(k)) begin
            proj_ena[k] = en;
            ow_slot     = bus.proj_ow[k*OW_W +: OW_W];
         end
      end
   end

   for (genvar k = 0; k < N_PROJ; k++) begin : g_iw
      assign proj_iw[k*IW_W +: IW_W] = proj_ena[k] ? bus.iw : '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ow_q <= '0;
      end else begin
         ow_q <= hold ? ow_slot : '0;
      end
   end

   assign bus.proj_ena = proj_ena;
   assign bus.proj_iw  = proj_iw;
   assign bus.ow       = ow_q;
   assign bus.busy     = busy;
   assign bus.cur_addr = cur_addr;

endmodule

// File: tb/tb_param_project_mux.sv
// Directed and random checks of param_project_mux against a timestamp-based reference.
module tb_param_project_mux;

   localparam int NP = 16;
   localparam int AW = 5;
   localparam int IW = 18;
   localparam int OW = 24;
   localparam int G  = 2;

   logic clk;
   logic rst;

   param_project_mux_if #(.N_PROJ(NP), .ADDR_W(AW), .IW_W(IW), .OW_W(OW)) bus ();

   param_project_mux #(
      .N_PROJ (NP),
      .ADDR_W (AW),
      .IW_W   (IW),
      .OW_W   (OW),
      .GUARD  (G)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_err    = 0;
   int n_checks = 0;

   // Reference: a selection is a session starting at cycle m_t0; the project is
   // enabled from m_t0+G on, and its output is captured from m_t0+G+2 on.
   int              cyc  = 0;
   int              m_t0 = 0;
   bit              m_on = 1'b0;
   logic [AW-1:0]   m_addr = '0;
   logic [OW-1:0]   exp_ow = '0;

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_on   = 1'b0;
      m_addr = '0;
      exp_ow = '0;
   endtask

   task automatic model_edge();
      bit act_prev;
      act_prev = m_on && (cyc >= m_t0 + G + 1);
      cyc++;
      if (rst) begin
         model_reset();
         return;
      end
      if (!bus.ena) begin
         m_on = 1'b0;
      end else if (bus.sel_load && (int'(bus.addr) >= NP)) begin
         m_addr = bus.addr;
         m_on   = 1'b0;
      end else if (bus.sel_load && !(act_prev && bus.addr == m_addr)) begin
         m_addr = bus.addr;
         m_on   = 1'b1;
         m_t0   = cyc;
      end
      if (act_prev && m_on && m_t0 < cyc)
         exp_ow = bus.proj_ow[m_addr*OW +: OW];
      else
         exp_ow = '0;
   endtask

   task automatic check_all();
      logic [NP-1:0]    e_pe;
      logic [NP*IW-1:0] e_iw;
      e_pe = '0;
      if (m_on && cyc >= m_t0 + G) e_pe[m_addr] = 1'b1;
      e_iw = '0;
      for (int k = 0; k < NP; k++)
         if (e_pe[k]) e_iw[k*IW +: IW] = bus.iw;
      chk("proj_ena", bus.proj_ena, e_pe);
      chk("busy", bus.busy, (m_on && cyc <= m_t0 + G));
      chk("cur_addr", bus.cur_addr, m_addr);
      chk("ow", bus.ow, exp_ow);
      chk("proj_iw", bus.proj_iw, e_iw);
      chk("onehot", ($countones(bus.proj_ena) <= 1), 1'b1);
   endtask

   task automatic rand_data();
      bus.iw = IW'($urandom);
      for (int k = 0; k < NP; k++)
         bus.proj_ow[k*OW +: OW] = OW'($urandom);
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_all();
      rand_data();
   endtask

   task automatic load(input logic [AW-1:0] a);
      bus.addr     = a;
      bus.sel_load = 1'b1;
      step();
      bus.sel_load = 1'b0;
   endtask

   initial begin
      logic [OW-1:0] exp3;
      int r;
      rst          = 1'b1;
      bus.ena      = 1'b0;
      bus.addr     = '0;
      bus.sel_load = 1'b0;
      rand_data();
      model_reset();
      step();
      step();
      chk("rst_proj_ena", bus.proj_ena, 16'h0000);
      chk("rst_ow", bus.ow, 24'h0);
      rst = 1'b0;

      // no project until the first sel_load
      bus.ena = 1'b1;
      step();
      step();
      chk("idle_proj_ena", bus.proj_ena, 16'h0000);

      load(5'd3);
      chk("a3_iso0_busy", bus.busy, 1'b1);
      step();
      chk("a3_iso1_pe", bus.proj_ena, 16'h0000);
      step();
      chk("a3_enable_pe", bus.proj_ena, 16'h0008);
      chk("a3_enable_ow", bus.ow, 24'h0);
      step();
      chk("a3_active0_ow", bus.ow, 24'h0);
      chk("a3_active0_busy", bus.busy, 1'b0);
      exp3 = bus.proj_ow[3*OW +: OW];
      step();
      chk("a3_ow_slot", bus.ow, exp3);

      load(5'd7);
      chk("sw7_gap0", bus.proj_ena, 16'h0000);
      step();
      chk("sw7_gap1", bus.proj_ena, 16'h0000);
      step();
      chk("sw7_pe", bus.proj_ena, 16'h0080);
      step();
      step();

      load(5'd20);
      chk("inv_pe", bus.proj_ena, 16'h0000);
      chk("inv_ow", bus.ow, 24'h0);
      chk("inv_cur_addr", bus.cur_addr, 5'd20);
      step();

      load(5'd5);
      repeat (4) step();
      for (int i = 0; i < 4; i++) begin
         bus.addr     = 5'd5;
         bus.sel_load = 1'b1;
         step();
         chk("same5_pe", bus.proj_ena, 16'h0020);
         chk("same5_busy", bus.busy, 1'b0);
      end
      bus.sel_load = 1'b0;

      load(5'd2);
      load(5'd9);
      chk("re9_pe0", bus.proj_ena, 16'h0000);
      step();
      chk("re9_pe1", bus.proj_ena, 16'h0000);
      step();
      chk("re9_pe", bus.proj_ena, 16'h0200);
      repeat (3) step();

      // asynchronous reset between edges
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      chk("arst_pe", bus.proj_ena, 16'h0000);
      chk("arst_ow", bus.ow, 24'h0);
      chk("arst_busy", bus.busy, 1'b0);
      chk("arst_cur_addr", bus.cur_addr, 5'd0);
      step();
      rst = 1'b0;
      step();

      load(5'd4);
      repeat (4) step();
      bus.ena = 1'b0;
      step();
      chk("enaoff_pe", bus.proj_ena, 16'h0000);
      chk("enaoff_ow", bus.ow, 24'h0);
      bus.ena = 1'b1;

      for (int i = 0; i < 400; i++) begin
         bus.ena      = ($urandom_range(0, 19) != 0);
         bus.sel_load = ($urandom_range(0, 3) == 0);
         r = int'($urandom_range(0, 9));
         if (r == 0)     bus.addr = AW'($urandom_range(16, 31));
         else if (r < 3) bus.addr = m_addr;
         else            bus.addr = AW'($urandom_range(0, 15));
         step();
      end
      bus.sel_load = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
